// File: rtl/mulu_ddr_seq_pkg.sv
// Shared configuration for the dual-edge operand sequencer.
// Holds the default widths, the FSM state encoding and the beat-count derivation.
package mulu_ddr_seq_pkg;

    localparam int DW_DEFAULT  = 6;
    localparam int OPW_DEFAULT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of two-lane beats needed to carry both operands, rounded up
    function automatic int calc_beats(input int dw, input int opw);
        return (2 * opw + 2 * dw - 1) / (2 * dw);
    endfunction

endpackage

// File: rtl/mulu_ddr_seq_shift_add.sv
// Unsigned shift-add multiply core: loads both operands in one cycle,
// then performs one partial-product accumulation per step.
module mulu_shift_add_core #(
    parameter int OPW = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             last,
    output logic [2*OPW-1:0] product
);

    localparam int IW = (OPW > 1) ? $clog2(OPW) : 1;

    logic [OPW-1:0]   mcand;
    logic [OPW-1:0]   mplier;
    logic [2*OPW-1:0] acc;
    logic [IW-1:0]    iter;
    logic [2*OPW-1:0] mcand_ext;

    assign mcand_ext = {{OPW{1'b0}}, mcand};
    assign last      = (iter == IW'(OPW - 1));
    assign product   = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            iter   <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            iter   <= '0;
        end else if (step) begin
            // Multiplier bit consumed LSB first; its weight tracks iter
            if (mplier[0]) begin
                acc <= acc + (mcand_ext << iter);
            end
            mplier <= mplier >> 1;
            iter   <= iter + IW'(1);
        end
    end

endmodule

// File: rtl/mulu_ddr_seq.sv
// Assembles two unsigned operands from dual-edge lane beats, multiplies them
// with the shift-add core and holds the product with a valid flag.
module mulu_ddr_seq
    import mulu_ddr_seq_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int OPW = OPW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DW-1:0]    in_pos,
    input  logic [DW-1:0]    in_neg,
    output logic             busy,
    output logic             result_valid,
    output logic [2*OPW-1:0] result
);

    localparam int BEATS = calc_beats(DW, OPW);
    localparam int BW    = BEATS * 2 * DW;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   beat_cnt;
    logic [BW-1:0]   asm_buf;
    logic [BW-1:0]   assembled;
    logic [2*DW-1:0] beat;
    logic            accept_start;
    logic            capture;
    logic            core_load;
    logic            core_step;
    logic            core_last;

    assign beat         = {in_neg, in_pos};
    assign accept_start = start && (state == ST_IDLE || state == ST_DONE);
    assign capture      = accept_start || (state == ST_LOAD);

    // Buffer contents including the beat on the lanes this cycle, so the
    // final beat can feed the core without an extra cycle
    always_comb begin
        assembled = BW'(beat);
        if (state == ST_LOAD) begin
            assembled = asm_buf;
            assembled[int'(beat_cnt) * 2 * DW +: 2 * DW] = beat;
        end
    end

    always_comb begin
        state_next = state;
        core_load  = 1'b0;
        core_step  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (BEATS == 1) begin
                        core_load  = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (beat_cnt == CW'(BEATS - 1)) begin
                    core_load  = 1'b1;
                    state_next = ST_MUL;
                end
            end
            ST_MUL: begin
                core_step = 1'b1;
                if (core_last) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            asm_buf  <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                asm_buf <= assembled;
            end
            if (accept_start) begin
                beat_cnt <= CW'(1);
            end else if (state == ST_LOAD) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    mulu_shift_add_core #(
        .OPW(OPW)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (core_load),
        .step   (core_step),
        .a      (assembled[OPW-1:0]),
        .b      (assembled[2*OPW-1:OPW]),
        .last   (core_last),
        .product(result)
    );

    assign busy         = (state == ST_LOAD) || (state == ST_MUL);
    assign result_valid = (state == ST_DONE);

endmodule
